seq_mult_arbiter: RTL and testbench

Shares one seq_mult sequential multiplier between NUM_REQ requesters, for example the PicoRV PCPI port plus accelerator clients. Per cycle it does three things: round-robin arbitration over valid/ready request channels, sequencing of the multiplier through a start pulse, and return of the 2*WIDTH-bit two's-complement product to the granted requester. It sits between the requesters and the multiplier instance and is the only driver of that instance.

---
 rtl/seq_mult_arbiter_pkg.sv | 18 +
 rtl/seq_mult_arbiter_if.sv | 33 +++
 rtl/seq_mult_arbiter_rr_arbiter.sv | 30 +++
 rtl/seq_mult_arbiter.sv | 134 +++++++++++++
 tb/tb_seq_mult_arbiter.sv | 209 ++++++++++++++++++++
 5 files changed

// File: rtl/seq_mult_arbiter_pkg.sv
// Shared types and constants for the seq_mult arbiter slice.
package seq_mult_arb_pkg;

    localparam int unsigned WIDTH_DEF  = 8;
    localparam int unsigned PROD_W_DEF = 2 * WIDTH_DEF;

    typedef enum logic [1:0] {
        IDLE,
        START,
        WAIT,
        RESP
    } state_t;

    function automatic int unsigned prod_width(input int unsigned w);
        return 2 * w;
    endfunction

endpackage

// File: rtl/seq_mult_arbiter_if.sv
// Requester channels and multiplier-side signals of the seq_mult arbiter.
interface seq_mult_arbiter_if
    import seq_mult_arb_pkg::*;
#(
    parameter int unsigned WIDTH   = WIDTH_DEF,
    parameter int unsigned NUM_REQ = 4
);

    logic [NUM_REQ-1:0]         req_valid;
    logic [NUM_REQ-1:0]         req_ready;
    logic [NUM_REQ*WIDTH-1:0]   req_a;
    logic [NUM_REQ*WIDTH-1:0]   req_b;
    logic [NUM_REQ-1:0]         resp_valid;
    logic [NUM_REQ-1:0]         resp_ready;
    logic [2*WIDTH-1:0]         resp_p;
    logic                       resp_err;
    logic                       mul_start;
    logic [WIDTH-1:0]           mul_a;
    logic [WIDTH-1:0]           mul_b;
    logic [2*WIDTH-1:0]         mul_p;
    logic                       mul_rdy;

    modport master (
        input  req_valid, req_a, req_b, resp_ready, mul_p, mul_rdy,
        output req_ready, resp_valid, resp_p, resp_err, mul_start, mul_a, mul_b
    );

    modport slave (
        output req_valid, req_a, req_b, resp_ready, mul_p, mul_rdy,
        input  req_ready, resp_valid, resp_p, resp_err, mul_start, mul_a, mul_b
    );

endinterface

// File: rtl/seq_mult_arbiter_rr_arbiter.sv
// Combinational round-robin pick: first asserted request at or after the pointer, with wrap.
module rr_arbiter #(
    parameter int unsigned NUM_REQ = 4,
    parameter int unsigned IDX_W   = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] i_req,
    input  logic [IDX_W-1:0]   i_ptr,
    output logic [NUM_REQ-1:0] o_grant,
    output logic [IDX_W-1:0]   o_idx,
    output logic               o_any
);

    logic [IDX_W-1:0] w_pos;

    always_comb begin
        o_grant = '0;
        o_idx   = '0;
        o_any   = 1'b0;
        w_pos   = '0;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            w_pos = IDX_W'((32'(i_ptr) + i) % NUM_REQ);
            if (!o_any && i_req[w_pos]) begin
                o_any          = 1'b1;
                o_grant[w_pos] = 1'b1;
                o_idx          = w_pos;
            end
        end
    end

endmodule

// File: rtl/seq_mult_arbiter.sv
// Round-robin front end sharing one seq_mult multiplier between NUM_REQ requesters.
// Optional watchdog enabled by defining SEQ_MULT_ARB_TIMEOUT_EN.
module seq_mult_arbiter
    import seq_mult_arb_pkg::*;
#(
    parameter int unsigned WIDTH      = WIDTH_DEF,
    parameter int unsigned NUM_REQ    = 4,
    parameter int unsigned TMO_CYCLES = 64
) (
    input  logic               clk,
    input  logic               reset,
    seq_mult_arbiter_if.master bus
);

    localparam int unsigned IDX_W  = $clog2(NUM_REQ);
    localparam int unsigned PROD_W = prod_width(WIDTH);

    if (NUM_REQ < 2 || NUM_REQ > 8 || TMO_CYCLES < 1) begin : g_bad_params
        $error("seq_mult_arbiter: NUM_REQ must be 2..8 and TMO_CYCLES >= 1");
    end

    state_t              r_state;
    logic [IDX_W-1:0]    r_ptr;
    logic [IDX_W-1:0]    r_gidx;
    logic                r_first;
    logic [NUM_REQ-1:0]  r_resp_valid;
    logic [PROD_W-1:0]   r_resp_p;
    logic                r_mul_start;
    logic [WIDTH-1:0]    r_mul_a;
    logic [WIDTH-1:0]    r_mul_b;

    logic [NUM_REQ-1:0]  w_grant;
    logic [IDX_W-1:0]    w_gidx;
    logic                w_any;

`ifdef SEQ_MULT_ARB_TIMEOUT_EN
    localparam int unsigned TMO_W = $clog2(TMO_CYCLES + 1);
    logic [TMO_W-1:0]    r_tmo;
    logic                r_resp_err;
    assign bus.resp_err = r_resp_err;
`else
    assign bus.resp_err = 1'b0;
`endif

    rr_arbiter #(
        .NUM_REQ (NUM_REQ),
        .IDX_W   (IDX_W)
    ) u_rr_arbiter (
        .i_req   (bus.req_valid),
        .i_ptr   (r_ptr),
        .o_grant (w_grant),
        .o_idx   (w_gidx),
        .o_any   (w_any)
    );

    // Accept strobe is combinational so the grant and operand capture share one cycle.
    assign bus.req_ready  = (r_state == IDLE) ? w_grant : '0;
    assign bus.resp_valid = r_resp_valid;
    assign bus.resp_p     = r_resp_p;
    assign bus.mul_start  = r_mul_start;
    assign bus.mul_a      = r_mul_a;
    assign bus.mul_b      = r_mul_b;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state      <= IDLE;
            r_ptr        <= '0;
            r_gidx       <= '0;
            r_first      <= 1'b0;
            r_resp_valid <= '0;
            r_resp_p     <= '0;
            r_mul_start  <= 1'b0;
            r_mul_a      <= '0;
            r_mul_b      <= '0;
`ifdef SEQ_MULT_ARB_TIMEOUT_EN
            r_tmo        <= '0;
            r_resp_err   <= 1'b0;
`endif
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_any) begin
                        r_gidx      <= w_gidx;
                        r_mul_a     <= bus.req_a[w_gidx*WIDTH +: WIDTH];
                        r_mul_b     <= bus.req_b[w_gidx*WIDTH +: WIDTH];
                        r_mul_start <= 1'b1;
                        r_state     <= START;
                    end
                end
                START: begin
                    r_mul_start <= 1'b0;
                    r_first     <= 1'b1;
`ifdef SEQ_MULT_ARB_TIMEOUT_EN
                    r_tmo       <= '0;
`endif
                    r_state     <= WAIT;
                end
                WAIT: begin
                    // First WAIT cycle is the multiplier's release cycle; its rdy is stale.
                    r_first <= 1'b0;
                    if (!r_first && bus.mul_rdy) begin
                        r_resp_p             <= bus.mul_p;
                        r_resp_valid         <= '0;
                        r_resp_valid[r_gidx] <= 1'b1;
                        r_state              <= RESP;
                    end
`ifdef SEQ_MULT_ARB_TIMEOUT_EN
                    else if (r_tmo == TMO_W'(TMO_CYCLES - 1)) begin
                        r_resp_p             <= '0;
                        r_resp_err           <= 1'b1;
                        r_resp_valid         <= '0;
                        r_resp_valid[r_gidx] <= 1'b1;
                        r_state              <= RESP;
                    end else begin
                        r_tmo <= r_tmo + TMO_W'(1);
                    end
`endif
                end
                RESP: begin
                    if (bus.resp_ready[r_gidx]) begin
                        r_resp_valid <= '0;
`ifdef SEQ_MULT_ARB_TIMEOUT_EN
                        r_resp_err   <= 1'b0;
`endif
                        r_ptr        <= (r_gidx == IDX_W'(NUM_REQ - 1)) ? '0 : r_gidx + IDX_W'(1);
                        r_state      <= IDLE;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_seq_mult_arbiter.sv
// Directed bench for seq_mult_arbiter with a behavioural 2*WIDTH-cycle seq_mult model.
module tb_seq_mult_arbiter;

    logic clk;
    logic reset;
    logic rdy_stuck;
    int   n_assert;
    int   n_fail;
    int   w;

    seq_mult_arbiter_if #(.WIDTH(8), .NUM_REQ(4)) bus ();

    seq_mult_arbiter #(
        .WIDTH      (8),
        .NUM_REQ    (4),
        .TMO_CYCLES (64)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Multiplier model: loads on mul_start (ORed with system reset), done 16 cycles after release.
    logic [4:0]         m_cnt;
    logic signed [15:0] m_prod;
    always @(posedge clk or posedge reset) begin
        if (reset) begin
            m_cnt  <= '0;
            m_prod <= '0;
        end else if (bus.mul_start) begin
            m_cnt  <= '0;
            m_prod <= $signed(bus.mul_a) * $signed(bus.mul_b);
        end else if (m_cnt != 5'd16) begin
            m_cnt <= m_cnt + 5'd1;
        end
    end
    assign bus.mul_rdy = (m_cnt == 5'd16) && !rdy_stuck;
    assign bus.mul_p   = bus.mul_rdy ? m_prod : 16'hDEAD;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic set_req(input int g, input logic [7:0] a, input logic [7:0] b);
        bus.req_a[g*8 +: 8] = a;
        bus.req_b[g*8 +: 8] = b;
        bus.req_valid[g]    = 1'b1;
    endtask

    // Returns on the START-cycle negedge; waited = IDLE cycles spent before the grant.
    task automatic grant_chk(input int g, input string tag, output int waited);
        #1;
        waited = 0;
        while (bus.req_ready == '0 && waited < 50) begin
            @(negedge clk);
            waited++;
        end
        chk({tag, "_grant"}, 32'(bus.req_ready), 32'(1) << g);
        @(negedge clk);
        bus.req_valid[g] = 1'b0;
        chk({tag, "_start"}, 32'(bus.mul_start), 32'd1);
    endtask

    task automatic resp_chk(input int g, input logic [15:0] p, input logic err,
                            input string tag, output int waited);
        waited = 0;
        while (bus.resp_valid == '0 && waited < 200) begin
            @(negedge clk);
            waited++;
        end
        chk({tag, "_rvalid"}, 32'(bus.resp_valid), 32'(1) << g);
        chk({tag, "_p"}, 32'(bus.resp_p), 32'(p));
        chk({tag, "_err"}, 32'(bus.resp_err), 32'(err));
        bus.resp_ready = 4'(32'(1) << g);
        @(negedge clk);
        bus.resp_ready = '0;
        chk({tag, "_done"}, {30'd0, bus.resp_valid != '0, bus.resp_err}, 32'd0);
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
    endtask

    initial begin
        n_assert       = 0;
        n_fail         = 0;
        reset          = 1'b1;
        rdy_stuck      = 1'b0;
        bus.req_valid  = '0;
        bus.req_a      = '0;
        bus.req_b      = '0;
        bus.resp_ready = '0;
        repeat (3) @(negedge clk);

        chk("rst_req_ready", 32'(bus.req_ready), 32'd0);
        chk("rst_resp_valid", 32'(bus.resp_valid), 32'd0);
        chk("rst_resp_p", 32'(bus.resp_p), 32'd0);
        chk("rst_resp_err", 32'(bus.resp_err), 32'd0);
        chk("rst_mul_start", 32'(bus.mul_start), 32'd0);
        chk("rst_mul_a", 32'(bus.mul_a), 32'd0);
        chk("rst_mul_b", 32'(bus.mul_b), 32'd0);
        reset = 1'b0;

        // Single request: 3 * -2, resp_valid 19 cycles after req_ready
        @(negedge clk);
        set_req(0, 8'd3, 8'hFE);
        grant_chk(0, "t1", w);
        chk("t1_mul_a", 32'(bus.mul_a), 32'h03);
        chk("t1_mul_b", 32'(bus.mul_b), 32'hFE);
        @(negedge clk);
        chk("t1_start_pulse", 32'(bus.mul_start), 32'd0);
        resp_chk(0, 16'hFFFA, 1'b0, "t1", w);
        chk("t1_latency", 32'(2 + w), 32'd19);

        // All four valid from rr_ptr=0: served 0,1,2,3
        do_reset();
        set_req(0, 8'd5, 8'd7);
        set_req(1, 8'hF8, 8'hF8);
        set_req(2, 8'h7F, 8'h80);
        set_req(3, 8'h00, 8'd99);
        grant_chk(0, "t2r0", w);
        resp_chk(0, 16'h0023, 1'b0, "t2r0", w);
        grant_chk(1, "t2r1", w);
        resp_chk(1, 16'h0040, 1'b0, "t2r1", w);
        grant_chk(2, "t2r2", w);
        resp_chk(2, 16'hC080, 1'b0, "t2r2", w);
        grant_chk(3, "t2r3", w);
        resp_chk(3, 16'h0000, 1'b0, "t2r3", w);

        // Requester 2 streams while 1 waits: order 2,1,2; operands held through WAIT
        set_req(2, 8'd2, 8'd3);
        grant_chk(2, "t3a", w);
        set_req(1, 8'hFF, 8'd5);
        set_req(2, 8'd4, 8'd4);
        resp_chk(2, 16'h0006, 1'b0, "t3a", w);
        grant_chk(1, "t3b", w);
        chk("t3b_gap", 32'(w), 32'd0);
        resp_chk(1, 16'hFFFB, 1'b0, "t3b", w);
        grant_chk(2, "t3c", w);
        chk("t3c_gap", 32'(w), 32'd0);
        resp_chk(2, 16'h0010, 1'b0, "t3c", w);

        // Held RESP: stable outputs, no grant, foreign resp_ready ignored
        set_req(3, 8'h10, 8'h10);
        set_req(0, 8'hFF, 8'hFF);
        grant_chk(3, "t4a", w);
        w = 0;
        while (bus.resp_valid == '0 && w < 200) begin
            @(negedge clk);
            w++;
        end
        bus.resp_ready = 4'b0111;
        for (int i = 0; i < 10; i++) begin
            chk("t4_hold", {8'd0, bus.resp_valid, bus.req_ready, bus.resp_p},
                {8'd0, 4'b1000, 4'b0000, 16'h0100});
            @(negedge clk);
        end
        resp_chk(3, 16'h0100, 1'b0, "t4a", w);
        grant_chk(0, "t4b", w);
        chk("t4b_gap", 32'(w), 32'd0);
        resp_chk(0, 16'h0001, 1'b0, "t4b", w);

        // Asynchronous reset in the 5th WAIT cycle, then a fresh request
        set_req(1, 8'd9, 8'd9);
        grant_chk(1, "t5a", w);
        repeat (5) @(negedge clk);
        chk("t5_mul_a_pre", 32'(bus.mul_a), 32'd9);
        #1 reset = 1'b1;
        #1;
        chk("t5_rst_ctl", {28'd0, bus.req_ready != '0, bus.resp_valid != '0,
                           bus.resp_err, bus.mul_start}, 32'd0);
        chk("t5_rst_data", {bus.mul_a, bus.mul_b, bus.resp_p}, 32'd0);
        @(negedge clk);
        reset = 1'b0;
        set_req(2, 8'hF0, 8'h03);
        grant_chk(2, "t5b", w);
        resp_chk(2, 16'hFFD0, 1'b0, "t5b", w);

        // Multiplier never finishes
        rdy_stuck = 1'b1;
        set_req(0, 8'd1, 8'd1);
        grant_chk(0, "t6", w);
`ifdef SEQ_MULT_ARB_TIMEOUT_EN
        resp_chk(0, 16'h0000, 1'b1, "t6_tmo", w);
        chk("t6_tmo_wait", 32'(w), 32'd65);
`else
        set_req(3, 8'd2, 8'd2);
        repeat (1000) @(negedge clk);
        chk("t6_stall", {29'd0, bus.resp_valid != '0, bus.req_ready != '0, bus.mul_start}, 32'd0);
`endif
        rdy_stuck     = 1'b0;
        bus.req_valid = '0;
        do_reset();

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
